// File: rtl/dst_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : dst_stream_out
// Description : Reads the destination pixel memory back one address at a
//               time and presents each gray value on a valid/ready byte
//               stream toward the UART transmitter.
//               Optional build macro DST_STREAM_CHECKSUM_EN appends an
//               8-bit additive checksum byte after the last pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module dst_stream_out #(
    parameter int ADDR_BITS  = 13,
    parameter int NUM_PIXELS = 8192,
    parameter int PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [PIX_W-1:0]     mem_do,
    output logic [PIX_W-1:0]     tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
`ifdef DST_STREAM_CHECKSUM_EN
        ,
        S_CSUM  = 3'd5
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]       tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   xfer;
`ifdef DST_STREAM_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
    logic [7:0]             csum_next;
`endif

    // A byte leaves only when a valid byte is offered and the transmitter takes it.
    assign xfer = tx_valid_q & tx_ready;

`ifdef DST_STREAM_CHECKSUM_EN
    // Running checksum including the byte currently being transferred.
    assign csum_next = csum_q + 8'(tx_data_q);
`endif

    // Next-state and registered-output logic for the read/latch/send sequence.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef DST_STREAM_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    mem_addr_d = '0;
                    busy_d     = 1'b1;
`ifdef DST_STREAM_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            S_READ: begin
                // Memory samples mem_addr on this edge; data appears next cycle.
                state_d = S_LATCH;
            end
            S_LATCH: begin
                tx_data_d  = mem_do;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
`ifdef DST_STREAM_CHECKSUM_EN
                    csum_d     = csum_next;
`endif
                    if (mem_addr_q == c_LAST_ADDR) begin
`ifdef DST_STREAM_CHECKSUM_EN
                        // Checksum byte is offered straight away, no bubble.
                        state_d    = S_CSUM;
                        tx_data_d  = PIX_W'(csum_next);
                        tx_valid_d = 1'b1;
`else
                        state_d    = S_DONE;
                        done_d     = 1'b1;
`endif
                    end else begin
                        mem_addr_d = mem_addr_q + 1'b1;
                        state_d    = S_READ;
                    end
                end
            end
`ifdef DST_STREAM_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                end
            end
`endif
            S_DONE: begin
                // start is deliberately not looked at here.
                busy_d     = 1'b0;
                mem_addr_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                mem_addr_d = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DST_STREAM_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DST_STREAM_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign mem_addr = mem_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: doc/dst_stream_out.md
Name: dst_stream_out

Overview:
- Downstream stage of the grayscale filter pass. Once the filter has filled the destination pixel memory, this block reads it back one pixel at a time and presents each 8-bit gray value on a valid/ready byte stream.
- The stream feeds the UART transmitter, so the processed image can be dumped to the host.
- The block is the only reader of the destination memory's address port while it is busy.

Parameters:
- ADDR_BITS, 13, destination memory address width.
- NUM_PIXELS, 8192, pixels per frame; the last address streamed is NUM_PIXELS-1 (must be ≤ 2^ADDR_BITS).
- PIX_W, 8, gray pixel width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to stream a frame; sampled only in IDLE.
- mem_addr  out  ADDR_BITS  read address to the destination memory (registered).
- mem_do  in  PIX_W  destination memory read data; synchronous read, valid one cycle after the address.
- tx_data  out  PIX_W  byte to transmitter (registered).
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset_n low, any time, including mid-frame): the block asynchronously returns to IDLE and all outputs go to 0 (mem_addr, tx_data, tx_valid, busy, done). The internal pixel counter and checksum also clear.
- States are IDLE, READ, LATCH, SEND, DONE (plus CSUM when the optional feature is enabled).
- IDLE:
  - If start=1, go to READ with mem_addr=0 and busy=1.
  - Otherwise stay in IDLE.
- READ: mem_addr is stable and the memory samples it at this edge. Go to LATCH.
- LATCH: on the edge, tx_data<=mem_do and tx_valid<=1. Go to SEND.
- SEND:
  - Hold tx_data and tx_valid stable until a rising edge sees tx_valid&tx_ready=1. That edge completes the transfer.
  - On transfer, tx_valid<=0 on the same edge.
  - If mem_addr==NUM_PIXELS-1, go to DONE. Otherwise mem_addr<=mem_addr+1 and go to READ.
  - If tx_ready=0, stay in SEND indefinitely; nothing else changes.
- DONE: done=1 for exactly this one cycle, busy<=0 on exit, mem_addr<=0. Go to IDLE.
- Throughput: with tx_ready tied high, one byte is transferred every 3 cycles (READ, LATCH, SEND).
  - Latency from the start edge to the first tx_valid=1 is 2 cycles.
- start while busy=1 is ignored and not queued.
- start asserted in the same cycle as the DONE pulse is ignored. A new frame needs start while in IDLE.
- tx_ready while tx_valid=0 has no effect.
- mem_addr never exceeds NUM_PIXELS-1. There is no wrap-around inside a frame.
- The next frame restarts at address 0.
- Pixel data is passed through unmodified (no arithmetic on the data path).

Optional Feature:
- Macro: DST_STREAM_CHECKSUM_EN.
- Enabled:
  - An 8-bit checksum register clears on start acceptance.
  - On each completed pixel transfer, checksum <= checksum + tx_data (mod 256).
  - After the last pixel transfer, SEND goes to CSUM instead of DONE.
  - CSUM presents tx_data=checksum, tx_valid=1, under the same handshake rules.
  - On transfer, the block goes to DONE.
  - Total bytes per frame = NUM_PIXELS+1.
- Disabled: no CSUM state and no checksum logic; exactly NUM_PIXELS bytes per frame.

Test Plan:
- Reset mid-frame: assert reset_n=0 while in SEND with mem_addr=5 and tx_valid=1 → tx_valid, busy, mem_addr and done all read 0 immediately. After release, start streams again from address 0.
- Full frame with NUM_PIXELS=4 and memory {0x10,0x20,0x30,0x40}, tx_ready=1, pulse start:
  - Bytes 0x10,0x20,0x30,0x40 are accepted on cycles 3, 6, 9, 12 after start.
  - done pulses one cycle after the last byte and busy falls.
- Backpressure: tx_ready=0 for 7 cycles during the second byte → tx_data=0x20 stays stable with tx_valid=1, mem_addr=1 is held, and no byte is lost or duplicated.
- start pulsed while busy, and again on the DONE cycle → both ignored; exactly one frame of 4 bytes is sent.
- Back-to-back frames: start pulsed in IDLE right after done → the second frame begins at address 0 and repeats 0x10…0x40.
- With DST_STREAM_CHECKSUM_EN and the same 4-pixel frame → a fifth byte 0xA0 (0x10+0x20+0x30+0x40) is sent, then done. With memory all 0xFF and NUM_PIXELS=4, the checksum byte is 0xFC.
